fsm_phase_monitor: RTL
======================

FSM_PHASE_MONITOR -- requirements
Module: fsm_phase_monitor

Interface
REQ-001 Parameter: LOCK_STREAK, default 4, consecutive legal in-order samples required to enter LOCKED.
REQ-002 Parameter: ERR_CNT_W, default 8, width of err_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 fsm0, fsm1, fsm2, fsm3  input  1 each  one-hot phase strobes from the four-phase sequencer.
REQ-006 clr_err  input  1  single-cycle request: clear err and err_code, return FAULT to SEARCH.
REQ-007 phase  output  2  encoded index of the last legal sample.
REQ-008 phase_valid  output  1  last sample was exactly one-hot.
REQ-009 locked  output  1  state == LOCKED.
REQ-010 err  output  1  sticky fault flag.
REQ-011 err_code  output  2  00 none, 01 MULTI (more than one strobe high), 10 DROP (no strobe high), 11 SEQ (one-hot but wrong successor).
REQ-012 err_count  output  ERR_CNT_W  faults detected since reset.
REQ-013 round_count  output  16  completed phase-3 samples while LOCKED.
REQ-014 round_done  output  1  one-cycle pulse per completed round.

Function
REQ-015 The block SHALL sample fsm0..fsm3 on every rising clk; all outputs are registered and reflect the sample taken at that edge (latency 1 edge, no combinational input-to-output path).
REQ-016 Successor rule: the legal successor of phase p is (p+1) mod 4; phase 3 wraps to 0.
REQ-017 States: SEARCH, LOCKED, FAULT.
REQ-018 SEARCH: legal sample equal to successor of the previous legal sample increments streak; any other legal sample sets streak=1; MULTI or DROP sets streak=0; no error is raised.
REQ-019 SEARCH -> LOCKED on the edge where streak reaches LOCK_STREAK; the phase-3 sample completing lock does not pulse round_done.
REQ-020 LOCKED: each sample SHALL be one-hot and the successor of phase; any violation -> FAULT, err=1, err_code per REQ-011, err_count+1.
REQ-021 FAULT: holds; err, err_code and phase are frozen; further violations are not counted; on clr_err -> SEARCH, streak=0, err=0, err_code=00.
REQ-022 clr_err in SEARCH or LOCKED SHALL have no effect; clr_err coincident with a LOCKED violation: violation wins (FAULT entered and counted).
REQ-023 round_done SHALL pulse exactly one cycle for each legal in-order phase-3 sample in LOCKED, and round_count increments on the same edge.
REQ-024 round_count SHALL wrap from 65535 to 0; err_count SHALL saturate at all-ones.
REQ-025 phase updates only on legal samples outside FAULT; phase_valid updates every cycle.
REQ-026 err_count and round_count SHALL be cleared only by reset, never by clr_err.

Reset
REQ-027 While rst_n=0: state=SEARCH, streak=0, phase=0, phase_valid=0, locked=0, err=0, err_code=00, err_count=0, round_count=0, round_done=0.
REQ-028 Reset asserted mid-round or in FAULT SHALL clear immediately, without waiting for clk; the first sample after release starts a fresh streak.

Structure
REQ-029 Shared package fsm_phase_pkg SHALL hold the state enum, the err_code constants and the phase-index type.
REQ-030 One-hot-to-index encoding plus the MULTI/DROP flags SHALL live in a combinational sub-module fsm_onehot_enc.

Verification
REQ-031 Reset then 0,1,2,3,0,1,2,3 -> locked=1 after 4th sample; round_done pulses on the second phase-3 sample only; round_count=1.
REQ-032 Locked, inject fsm1=fsm2=1 -> next edge err=1, err_code=01, err_count=1, locked=0; continued garbage leaves err_count=1.
REQ-033 Locked, expected phase 2, drive phase 3 -> err_code=11; pulse clr_err -> err=0, SEARCH; 4 good samples -> relock.
REQ-034 Locked, all strobes 0 for one cycle -> err_code=10; in SEARCH the same stimulus raises no error.
REQ-035 Preload by running 65536 rounds -> round_count wraps to 0; 300 forced faults -> err_count holds at 255.
REQ-036 Assert rst_n low between clk edges while in FAULT -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/fsm_phase_pkg.sv
// fsm_phase_pkg
//   Shared definitions for the four-phase sequencer monitor:
//   - state_e   : monitor FSM states (SEARCH, LOCKED, FAULT)
//   - phase_t   : encoded phase index 0..3
//   - ERR_*     : err_code values reported on a fault
//   - next_phase: legal successor of a phase (3 wraps to 0)
package fsm_phase_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    typedef logic [1:0] phase_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MULTI = 2'b01;
    localparam logic [1:0] ERR_DROP  = 2'b10;
    localparam logic [1:0] ERR_SEQ   = 2'b11;

    // Two-bit addition wraps 3 -> 0 naturally.
    function automatic phase_t next_phase(input phase_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/fsm_onehot_enc.sv
// fsm_onehot_enc
//   Combinational one-hot to index encoder for the four phase strobes.
//   Ports:
//     strobe : in  [3:0] phase strobes, bit n = phase n
//     idx    : out [1:0] index of the set bit (only meaningful when legal)
//     multi  : out       more than one strobe high
//     drop   : out       no strobe high
module fsm_onehot_enc
    import fsm_phase_pkg::*;
(
    input  logic [3:0] strobe,
    output phase_t     idx,
    output logic       multi,
    output logic       drop
);

    always_comb begin
        drop  = (strobe == 4'b0000);
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = ((strobe & (strobe - 4'd1)) != 4'b0000);
        case (strobe)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/fsm_phase_monitor.sv
// fsm_phase_monitor
//   Watches the one-hot phase strobes of a four-phase sequencer, locks onto
//   a clean in-order stream, and flags the first violation once locked.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     fsm0..fsm3         : one-hot phase strobes
//     clr_err            : leave FAULT and clear err/err_code
//     phase              : index of the last legal (one-hot) sample
//     phase_valid        : last sample was exactly one-hot
//     locked             : monitor is in LOCKED
//     err, err_code      : sticky fault flag and its cause
//     err_count          : faults since reset, saturating
//     round_count        : completed phase-3 samples while LOCKED, wrapping
//     round_done         : one-cycle pulse per completed round
//     dbg_state          : current FSM state (state_e encoding)
//   Handshake: there is none; every rising edge takes one sample and all
//   outputs are registered, reflecting the sample taken at that edge.
module fsm_phase_monitor
    import fsm_phase_pkg::*;
#(
    parameter int LOCK_STREAK = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fsm0,
    input  logic                 fsm1,
    input  logic                 fsm2,
    input  logic                 fsm3,
    input  logic                 clr_err,
    output logic [1:0]           phase,
    output logic                 phase_valid,
    output logic                 locked,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          round_count,
    output logic                 round_done,
    output logic [1:0]           dbg_state
);

    localparam int SW = $clog2(LOCK_STREAK + 1);
    localparam logic [SW-1:0]        LOCK_VAL   = SW'(LOCK_STREAK);
    localparam logic [SW-1:0]        STREAK_ONE = SW'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);

    phase_t enc_idx;
    logic   enc_multi;
    logic   enc_drop;
    logic   legal;
    logic   in_order;

    fsm_onehot_enc u_enc (
        .strobe ({fsm3, fsm2, fsm1, fsm0}),
        .idx    (enc_idx),
        .multi  (enc_multi),
        .drop   (enc_drop)
    );

    state_e                 state_q,       state_d;
    logic [SW-1:0]          streak_q,      streak_d;
    phase_t                 phase_q,       phase_d;
    logic                   phase_valid_q, phase_valid_d;
    logic                   err_q,         err_d;
    logic [1:0]             err_code_q,    err_code_d;
    logic [ERR_CNT_W-1:0]   err_count_q,   err_count_d;
    logic [15:0]            round_count_q, round_count_d;
    logic                   round_done_q,  round_done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SEARCH;
            streak_q      <= '0;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            err_count_q   <= '0;
            round_count_q <= 16'd0;
            round_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
            round_count_q <= round_count_d;
            round_done_q  <= round_done_d;
        end
    end

    always_comb begin
        legal    = !enc_multi && !enc_drop;
        in_order = legal && (enc_idx == next_phase(phase_q));

        state_d       = state_q;
        streak_d      = streak_q;
        phase_d       = phase_q;
        phase_valid_d = legal;
        err_d         = err_q;
        err_code_d    = err_code_q;
        err_count_d   = err_count_q;
        round_count_d = round_count_q;
        round_done_d  = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (!legal) begin
                    streak_d = '0;
                end else begin
                    phase_d = enc_idx;
                    // With streak at zero both branches yield one, so the
                    // first legal sample after reset or clear starts fresh.
                    streak_d = in_order ? (streak_q + STREAK_ONE) : STREAK_ONE;
                    if (streak_d == LOCK_VAL) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (in_order) begin
                    phase_d = enc_idx;
                    if (enc_idx == 2'd3) begin
                        round_done_d  = 1'b1;
                        round_count_d = round_count_q + 16'd1;
                    end
                end else begin
                    // clr_err is ignored here, so a coincident violation wins.
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    if (enc_multi) begin
                        err_code_d = ERR_MULTI;
                    end else if (enc_drop) begin
                        err_code_d = ERR_DROP;
                    end else begin
                        err_code_d = ERR_SEQ;
                    end
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_ONE;
                    end
                    // An out-of-order one-hot sample is still a legal sample.
                    if (legal) begin
                        phase_d = enc_idx;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_err) begin
                    state_d    = ST_SEARCH;
                    streak_d   = '0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = (state_q == ST_LOCKED);
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign err_count   = err_count_q;
    assign round_count = round_count_q;
    assign round_done  = round_done_q;
    assign dbg_state   = state_q;

endmodule
